safe_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one datapath resource (e.g. an instance of the team's safe one-hot FSM datapath) between N requesters. Its control state machine is one-hot, user-encoded and safe: any illegal state code is trapped into a dedicated recovery state, flagged, and returned to idle with no grant asserted. It sits between the requesting client blocks and the shared resource's enable/select inputs.

---
 rtl/safe_rr_arbiter_if.sv | 25 ++
 rtl/safe_rr_arbiter.sv | 127 ++++++++++++
 tb/tb_safe_rr_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/safe_rr_arbiter_if.sv
// Handshake bundle between N requesting clients and the shared-resource arbiter.
// Latency: none, plain wires.
// Backpressure: clients hold req until granted; the arbiter revokes via gnt.
interface safe_rr_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0] req;
  logic [N-1:0] done;
  logic [N-1:0] gnt;
  logic         busy;
  logic         timeout_err;
  logic         fault;

  // Requester side
  modport master (
    output req, done,
    input  gnt, busy, timeout_err, fault
  );

  // Arbiter side
  modport slave (
    input  req, done,
    output gnt, busy, timeout_err, fault
  );
endinterface

// File: rtl/safe_rr_arbiter.sv
// Round-robin arbiter for one shared resource; safe one-hot FSM traps illegal codes in RECOVERY.
// Latency: 1 cycle from request to grant out of IDLE, 0-cycle handoff between owners.
// Backpressure: requesters hold req until served; ownership is revoked after TIMEOUT cycles.
module safe_rr_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst,
  safe_rr_arbiter_if.slave io_arb
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = N + 2;

  // Named codes; GRANT_k is bit k+1 and is built from the owner index.
  typedef enum logic [SW-1:0] {
    ST_IDLE     = {{(SW-1){1'b0}}, 1'b1},
    ST_RECOVERY = {1'b1, {(SW-1){1'b0}}}
  } state_t;

  (* fsm_encoding = "user_encoding", fsm_safe_state = "default_state", syn_encoding = "user,safe" *)
  logic [SW-1:0] r_state;
  logic [IW-1:0] r_last;
  logic [7:0]    r_cnt;
  logic          r_terr;

  logic          w_onehot;
  logic          w_is_grant;
  logic [N-1:0]  w_gnt;
  logic [IW-1:0] w_owner;
  logic          w_own_req;
  logic          w_own_done;
  logic          w_at_limit;
  logic          w_rel;
  logic          w_rel_to_only;
  logic [N-1:0]  w_req_masked;
  logic [IW-1:0] w_win_all;
  logic [IW-1:0] w_win_masked;

  // First requester after i_last in cyclic order; i_last itself is considered last.
  function automatic logic [IW-1:0] f_winner(input logic [N-1:0] i_r, input logic [IW-1:0] i_last);
    logic [IW-1:0] v_idx;
    logic [IW-1:0] v_j;
    logic          v_found;
    v_idx   = i_last;
    v_found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      v_j = IW'((int'(i_last) + i) % N);
      if (!v_found && i_r[v_j]) begin
        v_idx   = v_j;
        v_found = 1'b1;
      end
    end
    return v_idx;
  endfunction

  function automatic logic [SW-1:0] f_grant_code(input logic [IW-1:0] i_k);
    return SW'(2) << i_k;
  endfunction

  // Decode state legality, current owner, release condition and next winners
  always_comb begin
    w_onehot   = (r_state != '0) && ((r_state & (r_state - SW'(1))) == '0);
    w_is_grant = w_onehot && !r_state[0] && !r_state[SW-1];
    // Grant lines come only from a legal GRANT code, so an illegal multi-hot code never leaks out.
    w_gnt      = w_is_grant ? r_state[N:1] : '0;
    w_owner    = '0;
    for (int k = 0; k < N; k++) begin
      if (r_state[k+1]) w_owner = IW'(k);
    end
    w_own_req     = io_arb.req[w_owner];
    w_own_done    = io_arb.done[w_owner];
    w_at_limit    = (r_cnt == 8'(TIMEOUT - 1));
    w_rel         = w_own_done || !w_own_req || w_at_limit;
    // A pure timeout must not hand the resource straight back to the same owner.
    w_rel_to_only = w_at_limit && !w_own_done && w_own_req;
    w_req_masked  = io_arb.req;
    if (w_rel_to_only) w_req_masked[w_owner] = 1'b0;
    w_win_all     = f_winner(io_arb.req, r_last);
    w_win_masked  = f_winner(w_req_masked, r_last);
  end

  // Control FSM with round-robin pointer, hold counter and timeout pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_last  <= IW'(N - 1);
      r_cnt   <= '0;
      r_terr  <= 1'b0;
    end else begin
      r_terr <= 1'b0;
      if (r_state == ST_IDLE) begin
        r_cnt <= '0;
        if (|io_arb.req) begin
          r_state <= f_grant_code(w_win_all);
          r_last  <= w_win_all;
        end
      end else if (w_is_grant) begin
        if (!w_rel) begin
          r_cnt <= r_cnt + 8'd1;
        end else begin
          r_cnt  <= '0;
          r_terr <= w_rel_to_only;
          if (|w_req_masked) begin
            r_state <= f_grant_code(w_win_masked);
            r_last  <= w_win_masked;
          end else begin
            r_state <= ST_IDLE;
          end
        end
      end else if (r_state == ST_RECOVERY) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        // Zero-hot or multi-hot code: trap, pointer kept as is.
        r_state <= ST_RECOVERY;
        r_cnt   <= '0;
      end
    end
  end

  assign io_arb.gnt         = w_gnt;
  assign io_arb.busy        = |w_gnt;
  assign io_arb.timeout_err = r_terr;
  assign io_arb.fault       = (r_state == ST_RECOVERY);

endmodule

// File: tb/tb_safe_rr_arbiter.sv
// Directed plus randomized bench for safe_rr_arbiter against an owner/pointer reference model.
module tb_safe_rr_arbiter;
  localparam int N       = 4;
  localparam int TIMEOUT = 15;

  logic clk;
  logic rst;
  int   n_asserts;
  int   n_fail;

  // Reference model: who owns the resource, who owned it last, how long, pending timeout pulse.
  int   m_owner;
  int   m_last;
  int   m_cnt;
  bit   m_terr;

  safe_rr_arbiter_if #(.N(N)) arb_if ();

  safe_rr_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_arb (arb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int last);
    int j;
    for (int i = 1; i <= N; i++) begin
      j = (last + i) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_gnt();
    if (m_owner < 0) return 4'b0000;
    return 4'(1 << m_owner);
  endfunction

  task automatic model_step();
    logic [3:0] r;
    logic [3:0] d;
    logic [3:0] mask;
    bit         rel_done;
    bit         rel_to;
    r = arb_if.req;
    d = arb_if.done;
    if (rst) begin
      m_owner = -1; m_last = N - 1; m_cnt = 0; m_terr = 0;
      return;
    end
    m_terr = 0;
    if (m_owner < 0) begin
      m_cnt = 0;
      if (r != 0) begin
        m_owner = pick(r, m_last);
        m_last  = m_owner;
      end
    end else begin
      rel_done = d[m_owner] || !r[m_owner];
      rel_to   = (m_cnt == TIMEOUT - 1);
      if (!rel_done && !rel_to) begin
        m_cnt++;
      end else begin
        mask  = r;
        m_cnt = 0;
        if (!rel_done) begin
          mask[m_owner] = 1'b0;
          m_terr = 1;
        end
        if (mask != 0) begin
          m_owner = pick(mask, m_last);
          m_last  = m_owner;
        end else begin
          m_owner = -1;
        end
      end
    end
  endtask

  // One clock: inputs were set in the low phase; outputs checked 1 time unit after the edge.
  task automatic tick(input bit use_model);
    if (use_model) model_step();
    @(posedge clk);
    #1;
    if (use_model) begin
      chk("gnt", 8'(arb_if.gnt), 8'(exp_gnt()));
      chk("busy", 8'(arb_if.busy), 8'(m_owner >= 0));
      chk("timeout_err", 8'(arb_if.timeout_err), 8'(m_terr));
      chk("fault", 8'(arb_if.fault), 8'd0);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] rot_exp [4];
    logic [3:0] rq;
    logic [3:0] dn;
    n_asserts = 0;
    n_fail    = 0;
    m_owner   = -1;
    m_last    = N - 1;
    m_cnt     = 0;
    m_terr    = 0;
    rst          = 1'b1;
    arb_if.req   = '0;
    arb_if.done  = '0;
    @(negedge clk);

    // Reset held with all requests high
    arb_if.req = 4'b1111;
    tick(1);
    tick(1);
    chk("rst_gnt", 8'(arb_if.gnt), 8'h0);
    chk("rst_busy", 8'(arb_if.busy), 8'h0);
    rst = 1'b0;
    tick(1);
    chk("first_gnt", 8'(arb_if.gnt), 8'h1);

    // Rotation with done pulses, no idle gaps
    rot_exp[0] = 4'b0010; rot_exp[1] = 4'b0100; rot_exp[2] = 4'b1000; rot_exp[3] = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      arb_if.done = exp_gnt();
      tick(1);
      chk("rotation", 8'(arb_if.gnt), 8'(rot_exp[i]));
    end
    arb_if.done = '0;

    // Sparse requesters 1 and 3 alternate
    arb_if.req = 4'b1010;
    tick(1);
    chk("sparse_first", 8'(arb_if.gnt), 8'h2);
    for (int i = 0; i < 4; i++) begin
      arb_if.done = exp_gnt();
      tick(1);
      chk("sparse_alt", 8'(arb_if.gnt), (i % 2 == 0) ? 8'h8 : 8'h2);
    end
    arb_if.done = '0;

    // Timeout: lone requester 0 held for exactly TIMEOUT cycles
    arb_if.req = 4'b0001;
    for (int i = 0; i < TIMEOUT; i++) begin
      tick(1);
      chk("to_hold", 8'(arb_if.gnt), 8'h1);
    end
    tick(1);
    chk("to_revoke_gnt", 8'(arb_if.gnt), 8'h0);
    chk("to_revoke_err", 8'(arb_if.timeout_err), 8'h1);
    tick(1);
    chk("to_regrant", 8'(arb_if.gnt), 8'h1);
    chk("to_err_pulse", 8'(arb_if.timeout_err), 8'h0);

    // done in the same cycle as the hold limit: normal release, no timeout pulse
    for (int i = 0; i < TIMEOUT - 1; i++) tick(1);
    arb_if.done = 4'b0001;
    tick(1);
    chk("done_at_limit_gnt", 8'(arb_if.gnt), 8'h1);
    chk("done_at_limit_err", 8'(arb_if.timeout_err), 8'h0);
    arb_if.done = '0;

    // Reset in the middle of a grant
    arb_if.req = 4'b0100;
    tick(1);
    chk("mid_gnt", 8'(arb_if.gnt), 8'h4);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_gnt", 8'(arb_if.gnt), 8'h0);
    rst = 1'b0;
    tick(1);
    chk("mid_after_rst", 8'(arb_if.gnt), 8'h4);

    // Illegal multi-hot state code
    arb_if.req = 4'b0000;
    tick(1);
    arb_if.req = 4'b0100;
    force dut.r_state = 6'b000110;
    #1;
    release dut.r_state;
    #1;
    chk("illegal_gnt", 8'(arb_if.gnt), 8'h0);
    chk("illegal_busy", 8'(arb_if.busy), 8'h0);
    tick(0);
    chk("recovery_fault", 8'(arb_if.fault), 8'h1);
    chk("recovery_gnt", 8'(arb_if.gnt), 8'h0);
    tick(0);
    chk("recovered_idle_fault", 8'(arb_if.fault), 8'h0);
    chk("recovered_idle_gnt", 8'(arb_if.gnt), 8'h0);
    tick(0);
    chk("recovered_grant", 8'(arb_if.gnt), 8'h4);
    m_owner = 2; m_last = 2; m_cnt = 0; m_terr = 0;

    // Randomized traffic against the model
    rq = 4'b0100;
    for (int c = 0; c < 500; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
      end
      dn = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) dn = dn & ~exp_gnt();
      if ($urandom_range(0, 7) == 0) dn = dn | exp_gnt();
      arb_if.req  = rq;
      arb_if.done = dn;
      rst = ($urandom_range(0, 199) == 0);
      tick(1);
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
